// File: rtl/pwm_breathe_multi.sv
// Multi-channel LED driver: one shared PWM counter and breathing-phase accumulator,
// per-channel off/on/blink/breathe modes with fixed phase offsets and glitch-free shadowing.
module pwm_breathe_multi #(
  parameter int CHANNELS   = 4,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 49019,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic                  freeze,
  output logic [CHANNELS-1:0]   led,
  output logic                  frame
);

  localparam int N         = PWM_BITS;
  localparam int MAX_I     = (1 << N) - 1;
  localparam int TWO_MAX_I = 2 * MAX_I;
  localparam int OFFSET    = TWO_MAX_I / CHANNELS;
  localparam int PRE_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [N-1:0]     MAX        = N'(MAX_I);
  localparam logic [N:0]       P_LAST     = (N+1)'(TWO_MAX_I - 1);
  localparam logic [N+1:0]     TWO_MAX_W  = (N+2)'(TWO_MAX_I);
  localparam logic [N-1:0]     TWO_MAX_LO = N'(TWO_MAX_I);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(STEP_DIV - 1);
  localparam logic             POL        = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  logic [N-1:0]        cnt;
  logic [PRE_W-1:0]    pre;
  logic [N:0]          p;
  logic [CHANNELS-1:0] on_vec;
  logic                load;

  // Shadows load on the last count of a period so new values apply from cnt==0.
  assign load = (cnt == MAX);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [N+1:0] OFS_I = (N+2)'(i * OFFSET);

    logic [N+1:0] sum;
    logic [N+1:0] pos;
    logic [N-1:0] lvl;
    logic         up;
    logic [N-1:0] duty_sh;
    mode_t        mode_sh;
    logic         up_sh;
    logic         on_i;

    always_comb begin
      sum = {1'b0, p} + OFS_I;
      pos = (sum >= TWO_MAX_W) ? sum - TWO_MAX_W : sum;
      up  = (pos < {2'b00, MAX});
      // On the falling half 2*MAX-pos < MAX, so the subtraction is exact modulo 2^N.
      lvl = (pos <= {2'b00, MAX}) ? pos[N-1:0] : TWO_MAX_LO - pos[N-1:0];
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        duty_sh <= '0;
        mode_sh <= MODE_OFF;
        up_sh   <= 1'b0;
      end else if (load) begin
        duty_sh <= lvl;
        mode_sh <= mode_t'(mode[2*i +: 2]);
        up_sh   <= up;
      end
    end

    always_comb begin
      on_i = 1'b0;
      case (mode_sh)
        MODE_OFF:     on_i = 1'b0;
        MODE_ON:      on_i = 1'b1;
        MODE_BLINK:   on_i = up_sh;
        MODE_BREATHE: on_i = (cnt < duty_sh);
        default:      on_i = 1'b0;
      endcase
    end

    assign on_vec[i] = on_i;
  end

  // NOTE: every register here uses <= so all reads see pre-edge values (shadow captures the pre-step level).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      pre   <= '0;
      p     <= '0;
      led   <= {CHANNELS{POL}};
      frame <= 1'b0;
    end else begin
      cnt   <= cnt + 1'b1;
      frame <= (cnt == '0);
      led   <= on_vec ^ {CHANNELS{POL}};
      if (!freeze) begin
        if (pre == PRE_LAST) begin
          pre <= '0;
          p   <= (p == P_LAST) ? '0 : p + 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Scoreboard bench for pwm_breathe_multi: a time-based reference model queues the
// expected led/frame per edge; an independent monitor pops and compares after each edge.
module tb_pwm_breathe_multi;

  localparam int CH      = 2;
  localparam int NB      = 3;
  localparam int SD      = 2;
  localparam int MAXV    = 7;
  localparam int TWO_MAX = 14;
  localparam int OFS     = TWO_MAX / CH;
  localparam int PER     = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*CH-1:0] mode;
  logic          freeze;
  logic [CH-1:0] led;
  logic          frame;

  typedef struct packed {
    logic [CH-1:0] led;
    logic          frame;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: edges since reset, unfrozen edges since reset, and shadow contents.
  int t   = 0;
  int run = 0;
  int sh_duty[CH];
  int sh_mode[CH];
  bit sh_up[CH];

  pwm_breathe_multi #(
    .CHANNELS(CH), .PWM_BITS(NB), .STEP_DIV(SD), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .freeze(freeze), .led(led), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int pos_of(input int p, input int i);
    return (p + i * OFS) % TWO_MAX;
  endfunction

  function automatic int level_of(input int p, input int i);
    int pos;
    pos = pos_of(p, i);
    return (pos <= MAXV) ? pos : TWO_MAX - pos;
  endfunction

  // Drive one edge's inputs, queue the response expected after that edge, advance the model.
  task automatic cycle(input logic r, input logic [2*CH-1:0] m, input logic f);
    exp_t e;
    int   c;
    int   p;
    bit   lit;
    rst_n  = r;
    mode   = m;
    freeze = f;
    if (!r) begin
      e.led   = '1;
      e.frame = 1'b0;
      t = 0;
      run = 0;
      for (int i = 0; i < CH; i++) begin
        sh_duty[i] = 0;
        sh_mode[i] = 0;
        sh_up[i]   = 1'b0;
      end
    end else begin
      c = t % PER;
      p = (run / SD) % TWO_MAX;
      e.frame = (c == 0);
      for (int i = 0; i < CH; i++) begin
        case (sh_mode[i])
          1:       lit = 1'b1;
          2:       lit = sh_up[i];
          3:       lit = (c < sh_duty[i]);
          default: lit = 1'b0;
        endcase
        e.led[i] = ~lit;
      end
      if (c == PER - 1) begin
        for (int i = 0; i < CH; i++) begin
          sh_duty[i] = level_of(p, i);
          sh_mode[i] = int'(m[2*i +: 2]);
          sh_up[i]   = (pos_of(p, i) < MAXV);
        end
      end
      t++;
      if (!f) run++;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("led", int'(led), int'(e.led));
        check("frame", int'(frame), int'(e.frame));
      end
    end
  end

  initial begin
    logic [2*CH-1:0] m;
    logic            f;
    logic            r;

    // Reset held with both channels in breathe: all dark, no frame.
    for (int k = 0; k < 5; k++) cycle(1'b0, 4'b1111, 1'b0);

    // ch0 on, ch1 off.
    for (int k = 0; k < 24; k++) cycle(1'b1, 4'b0001, 1'b0);

    // Frozen at P=0: ch0 duty 0, ch1 duty MAX.
    cycle(1'b0, 4'b1111, 1'b1);
    for (int k = 0; k < 32; k++) cycle(1'b1, 4'b1111, 1'b1);

    // Full breathe sweep on ch0 including the phase wrap.
    for (int k = 0; k < 28 * PER; k++) cycle(1'b1, 4'b0011, 1'b0);

    // Mid-frame switch from breathe to blink, then run blink over several breaths.
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'b0011, 1'b0);
    for (int k = 0; k < 3 * TWO_MAX * SD + 40; k++) cycle(1'b1, 4'b0010, 1'b0);

    // One-clock reset during a lit breathe frame, then restart.
    for (int k = 0; k < 45; k++) cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b0, 4'b1111, 1'b0);
    for (int k = 0; k < 40; k++) cycle(1'b1, 4'b1111, 1'b0);

    // Randomized modes, freeze and occasional reset.
    m = 4'b1111;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 19) == 0) m = 4'($urandom);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 299) != 0);
      cycle(r, m, f);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
